// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, LSB) share one registered broadcast port, round-robin.
// Optional `CDB_BYPASS_EN: an empty FIFO's incoming result may be broadcast on the same edge.
module cdb_arbiter #(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rdy_i,
    input  logic                 jp_wrong_i,
    input  logic                 alu_valid_i,
    input  logic [ROB_IDX_W-1:0] alu_idx_i,
    input  logic [DATA_W-1:0]    alu_val_i,
    output logic                 alu_full_o,
    input  logic                 lsb_valid_i,
    input  logic [ROB_IDX_W-1:0] lsb_idx_i,
    input  logic [DATA_W-1:0]    lsb_val_i,
    output logic                 lsb_full_o,
    output logic                 cdb_valid_o,
    output logic [ROB_IDX_W-1:0] cdb_idx_o,
    output logic [DATA_W-1:0]    cdb_val_o,
    output logic                 cdb_src_o
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = ROB_IDX_W + DATA_W;

    // Source index 0 = ALU, 1 = LSB throughout.
    logic [EntW-1:0] mem_q    [2][QDEPTH];
    logic [PtrW-1:0] wr_ptr_q [2];
    logic [PtrW-1:0] wr_ptr_d [2];
    logic [PtrW-1:0] rd_ptr_q [2];
    logic [PtrW-1:0] rd_ptr_d [2];
    logic [CntW-1:0] cnt_q    [2];
    logic [CntW-1:0] cnt_d    [2];

    logic                 last_q, last_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_idx_q, cdb_idx_d;
    logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
    logic                 cdb_src_q, cdb_src_d;

    logic [EntW-1:0] in_ent [2];
    logic [EntW-1:0] head   [2];
    logic [EntW-1:0] sel_ent;
    logic [1:0]      in_valid, empty, full, byp_req, req, gnt, pop, byp, push, push_en;
    logic            act;

    always_comb begin
        in_valid  = {lsb_valid_i, alu_valid_i};
        in_ent[0] = {alu_idx_i, alu_val_i};
        in_ent[1] = {lsb_idx_i, lsb_val_i};
        for (int s = 0; s < 2; s++) begin
            empty[s] = (cnt_q[s] == '0);
            full[s]  = (cnt_q[s] == CntW'(QDEPTH));
            head[s]  = mem_q[s][rd_ptr_q[s]];
        end
`ifdef CDB_BYPASS_EN
        byp_req = in_valid & empty;
`else
        byp_req = 2'b00;
`endif
        req    = ~empty | byp_req;
        // Tie goes to the source that did not win last time.
        gnt[1] = req[1] & (~req[0] | ~last_q);
        gnt[0] = req[0] & ~gnt[1];
        pop    = gnt & ~empty;
        byp    = gnt & empty;
        for (int s = 0; s < 2; s++) begin
            push[s] = in_valid[s] & ~byp[s] & (~full[s] | pop[s]);
        end
        if (gnt[1]) begin
            sel_ent = byp[1] ? in_ent[1] : head[1];
        end else begin
            sel_ent = byp[0] ? in_ent[0] : head[0];
        end
        act     = rdy_i & ~jp_wrong_i;
        push_en = push & {2{act}};
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        cdb_valid_d = cdb_valid_q;
        cdb_idx_d   = cdb_idx_q;
        cdb_val_d   = cdb_val_q;
        cdb_src_d   = cdb_src_q;
        if (rdy_i) begin
            if (jp_wrong_i) begin
                for (int s = 0; s < 2; s++) begin
                    wr_ptr_d[s] = '0;
                    rd_ptr_d[s] = '0;
                    cnt_d[s]    = '0;
                end
                cdb_valid_d = 1'b0;
                last_d      = 1'b1;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PtrW'(1);
                    if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PtrW'(1);
                    cnt_d[s] = cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
                end
                cdb_valid_d = |gnt;
                if (|gnt) begin
                    {cdb_idx_d, cdb_val_d} = sel_ent;
                    cdb_src_d              = gnt[1];
                    last_d                 = gnt[1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            last_q      <= 1'b1;
            cdb_valid_q <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_idx_q   <= cdb_idx_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (push_en[s]) mem_q[s][wr_ptr_q[s]] <= in_ent[s];
        end
    end

    assign alu_full_o  = full[0];
    assign lsb_full_o  = full[1];
    assign cdb_valid_o = cdb_valid_q;
    assign cdb_idx_o   = cdb_idx_q;
    assign cdb_val_o   = cdb_val_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-based reference model checked every cycle, plus literal pins.
module tb_cdb_arbiter;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1, jp = 1'b0;
    logic        alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [3:0]  alu_idx = '0, lsb_idx = '0;
    logic [31:0] alu_val = '0, lsb_val = '0;
    logic        alu_full, lsb_full, cdb_valid, cdb_src;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;

    int checks = 0;
    int failures = 0;

    cdb_arbiter #(.QDEPTH(QD), .ROB_IDX_W(4), .DATA_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .jp_wrong_i(jp),
        .alu_valid_i(alu_valid), .alu_idx_i(alu_idx), .alu_val_i(alu_val), .alu_full_o(alu_full),
        .lsb_valid_i(lsb_valid), .lsb_idx_i(lsb_idx), .lsb_val_i(lsb_val), .lsb_full_o(lsb_full),
        .cdb_valid_o(cdb_valid), .cdb_idx_o(cdb_idx), .cdb_val_o(cdb_val), .cdb_src_o(cdb_src)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per producer, results tagged {idx, val}.
    logic [35:0] aq[$];
    logic [35:0] lq[$];
    int          log_idx[$];
    logic        m_valid = 1'b0, m_src = 1'b0, m_last = 1'b1;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_val = '0;
    int          drops = 0;
    logic        saw_alu_full = 1'b0;

    task automatic model_step();
        bit ra, rl, ba, bl;
        int g;
        logic [35:0] e;
        if (!rst_n) begin
            aq.delete(); lq.delete();
            m_valid = 0; m_idx = 0; m_val = 0; m_src = 0; m_last = 1;
        end else if (rdy) begin
            if (jp) begin
                aq.delete(); lq.delete();
                m_valid = 0; m_last = 1;
            end else begin
                ra = aq.size() > 0; rl = lq.size() > 0; ba = 0; bl = 0;
`ifdef CDB_BYPASS_EN
                if (aq.size() == 0 && alu_valid) ra = 1;
                if (lq.size() == 0 && lsb_valid) rl = 1;
`endif
                g = -1;
                if (ra && rl) g = m_last ? 0 : 1;
                else if (ra) g = 0;
                else if (rl) g = 1;
                e = '0;
                if (g == 0) begin
                    if (aq.size() > 0) e = aq.pop_front();
                    else begin e = {alu_idx, alu_val}; ba = 1; end
                end else if (g == 1) begin
                    if (lq.size() > 0) e = lq.pop_front();
                    else begin e = {lsb_idx, lsb_val}; bl = 1; end
                end
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_idx = e[35:32]; m_val = e[31:0]; m_src = (g == 1); m_last = (g == 1);
                    log_idx.push_back(int'(e[35:32]));
                end
                if (alu_valid && !ba) begin
                    if (aq.size() < QD) aq.push_back({alu_idx, alu_val});
                    else drops++;
                end
                if (lsb_valid && !bl) begin
                    if (lq.size() < QD) lq.push_back({lsb_idx, lsb_val});
                    else drops++;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (alu_full) saw_alu_full = 1'b1;
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_idx", 64'(cdb_idx), 64'(m_idx));
        chk("cdb_val", 64'(cdb_val), 64'(m_val));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
        chk("alu_full", 64'(alu_full), 64'(aq.size() == QD));
        chk("lsb_full", 64'(lsb_full), 64'(lq.size() == QD));
    end

    task automatic cyc(input logic r, input logic j, input logic av, input logic [3:0] ai,
                       input logic [31:0] avv, input logic lv, input logic [3:0] li,
                       input logic [31:0] lvv);
        rdy = r; jp = j;
        alu_valid = av; alu_idx = ai; alu_val = avv;
        lsb_valid = lv; lsb_idx = li; lsb_val = lvv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lat_wait();
`ifndef CDB_BYPASS_EN
        idle(1);
`endif
    endtask

    task automatic check_log(input string name, input int base, input int e0, input int e1,
                             input int e2, input int e3, input int e4, input int e5);
        int exp_a[6];
        exp_a = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < 6; i++) begin
            if (base + i < log_idx.size()) chk(name, 64'(log_idx[base + i]), 64'(exp_a[i]));
            else chk(name, 64'hDEAD, 64'(exp_a[i]));
        end
    endtask

    int base;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset in the middle of traffic
        cyc(1, 0, 1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
        cyc(1, 0, 1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_alu_full", 64'(alu_full), 64'd0);
        chk("rst_lsb_full", 64'(lsb_full), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(cdb_valid), 64'd0);
        rst_n = 1'b1;

        // 2: single ALU result
        cyc(1, 0, 1, 4'd3, 32'h1234, 0, 0, 0);
        lat_wait();
        chk("t2_valid", 64'(cdb_valid), 64'd1);
        chk("t2_idx", 64'(cdb_idx), 64'd3);
        chk("t2_val", 64'(cdb_val), 64'h1234);
        chk("t2_src", 64'(cdb_src), 64'd0);
        idle(1);
        chk("t2_drop", 64'(cdb_valid), 64'd0);

        // 3: both streams alternate
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        base = log_idx.size();
        for (int i = 1; i <= 3; i++)
            cyc(1, 0, 1, 4'(i), 32'h100 + i, 1, 4'(8 + i), 32'h200 + i);
        idle(8);
        check_log("t3_order", base, 1, 9, 2, 10, 3, 11);

        // 4: fill ALU until a push is dropped
        for (int i = 0; i < 12; i++)
            cyc(1, 0, 1, 4'(i), 32'hA000 + i, 1, 4'(15 - i), 32'hB000 + i);
        chk("t4_full_seen", 64'(saw_alu_full), 64'd1);
        chk("t4_drop_seen", 64'(drops > 0), 64'd1);
        idle(20);

        // 5: mispredict flush
        cyc(1, 0, 1, 4'd1, 32'h11, 1, 4'd9, 32'h99);
        cyc(1, 0, 1, 4'd2, 32'h22, 1, 4'd10, 32'hAA);
        cyc(1, 0, 1, 4'd3, 32'h33, 0, 0, 0);
        cyc(1, 1, 1, 4'd7, 32'h77, 1, 4'd8, 32'h88);
        chk("t5_valid", 64'(cdb_valid), 64'd0);
        chk("t5_alu_full", 64'(alu_full), 64'd0);
        chk("t5_lsb_full", 64'(lsb_full), 64'd0);
        cyc(1, 0, 0, 0, 0, 1, 4'd5, 32'h55);
        lat_wait();
        chk("t5_next_valid", 64'(cdb_valid), 64'd1);
        chk("t5_next_idx", 64'(cdb_idx), 64'd5);
        chk("t5_next_src", 64'(cdb_src), 64'd1);
        chk("t5_next_val", 64'(cdb_val), 64'h55);
        idle(1);
        chk("t5_quiet", 64'(cdb_valid), 64'd0);

        // 6: freeze with rdy=0, alternation resumes
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        base = log_idx.size();
        for (int i = 1; i <= 3; i++)
            cyc(1, 0, 1, 4'(i), 32'h300 + i, 1, 4'(8 + i), 32'h400 + i);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 4'd14, 32'hEE, 1, 4'd15, 32'hFF);
        idle(10);
        check_log("t6_order", base, 1, 9, 2, 10, 3, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
